// File: rtl/adder_seq_n_if.sv
// adder_seq_n_if: request/response bundle for the digit-serial adder/subtractor.
//   start, a, b, cin, sub : request side, driven by the controller (master)
//   busy, done            : status, driven by the adder (slave)
//   sum, cout, ovf        : registered result, driven by the adder (slave)
// WIDTH must match the WIDTH of the adder_seq_n instance it is attached to.
interface adder_seq_n_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/adder_seq_n.sv
// adder_seq_n: digit-serial adder/subtractor, DIGIT bits per clock through one
// DIGIT-bit adder slice. Computes a+b+cin (sub=0) or a-b-cin (sub=1).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : adder_seq_n_if.slave
//           start/a/b/cin/sub sampled when a start is accepted (IDLE or DONE)
//           busy high for N = WIDTH/DIGIT cycles, done a one-cycle pulse after
//           which sum/cout/ovf hold the registered result
// Latency from the accepting edge to done is N+1 edges; start held high gives
// one result every N+1 cycles. WIDTH must be an integer multiple of DIGIT.
module adder_seq_n #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    adder_seq_n_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    // The A shift register doubles as the working sum register: each edge one
    // digit of A leaves at the bottom and one digit of sum enters at the top,
    // so after N digits it holds the complete result.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [DIGIT:0]   digit_full;
    logic [DIGIT-1:0] digit_sum;
    logic             digit_cout;
    logic             digit_cmsb;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;

    // Single DIGIT-bit adder slice.
    always_comb begin
        digit_full = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_reg};
        digit_sum  = digit_full[DIGIT-1:0];
        digit_cout = digit_full[DIGIT];
        // Carry into the slice MSB, recovered from the MSB sum bit.
        digit_cmsb = digit_sum[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];
    end

    generate
        if (DIGIT == WIDTH) begin : g_single
            assign a_next = digit_sum;
            assign b_next = '0;
        end else begin : g_serial
            assign a_next = {digit_sum, a_reg[WIDTH-1:DIGIT]};
            assign b_next = {{DIGIT{1'b0}}, b_reg[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        // Subtraction as a + ~b + 1: invert B and seed the
                        // carry so a borrow-in becomes "no +1".
                        b_reg     <= bus.b ^ {WIDTH{bus.sub}};
                        carry_reg <= bus.cin ^ bus.sub;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    a_reg     <= a_next;
                    b_reg     <= b_next;
                    carry_reg <= digit_cout;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_DIGIT) begin
                        sum_reg   <= a_next;
                        cout_reg  <= digit_cout;
                        ovf_reg   <= digit_cmsb ^ digit_cout;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_adder_seq_n.sv
module tb_adder_seq_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // sel 0: 16/4, sel 1: 4/1 (sweep), sel 2: 8/8, sel 3: 8/1
    adder_seq_n_if #(.WIDTH(16)) i16 ();
    adder_seq_n_if #(.WIDTH(4))  i4 ();
    adder_seq_n_if #(.WIDTH(8))  i8a ();
    adder_seq_n_if #(.WIDTH(8))  i8b ();

    adder_seq_n #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16));
    adder_seq_n #(.WIDTH(4),  .DIGIT(1)) u4  (.clk(clk), .rst_n(rst_n), .bus(i4));
    adder_seq_n #(.WIDTH(8),  .DIGIT(8)) u8a (.clk(clk), .rst_n(rst_n), .bus(i8a));
    adder_seq_n #(.WIDTH(8),  .DIGIT(1)) u8b (.clk(clk), .rst_n(rst_n), .bus(i8b));

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          due;
        string       name;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];
    exp_t q8a[$];
    exp_t q8b[$];

    function automatic int nval(input int sel);
        case (sel)
            0:       return 4;
            1:       return 4;
            2:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic int qsize(input int sel);
        case (sel)
            0:       return q16.size();
            1:       return q4.size();
            2:       return q8a.size();
            default: return q8b.size();
        endcase
    endfunction

    function automatic void qpush(input int sel, input exp_t e);
        case (sel)
            0:       q16.push_back(e);
            1:       q4.push_back(e);
            2:       q8a.push_back(e);
            default: q8b.push_back(e);
        endcase
    endfunction

    function automatic exp_t qpop(input int sel);
        case (sel)
            0:       return q16.pop_front();
            1:       return q4.pop_front();
            2:       return q8a.pop_front();
            default: return q8b.pop_front();
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [15:0] a,
                         input logic [15:0] b, input logic cin, input logic sub);
        case (sel)
            0: begin i16.start = st; i16.a = a;       i16.b = b;       i16.cin = cin; i16.sub = sub; end
            1: begin i4.start  = st; i4.a  = a[3:0];  i4.b  = b[3:0];  i4.cin  = cin; i4.sub  = sub; end
            2: begin i8a.start = st; i8a.a = a[7:0];  i8a.b = b[7:0];  i8a.cin = cin; i8a.sub = sub; end
            default: begin i8b.start = st; i8b.a = a[7:0]; i8b.b = b[7:0]; i8b.cin = cin; i8b.sub = sub; end
        endcase
    endtask

    task automatic set_start(input int sel, input logic st);
        case (sel)
            0:       i16.start = st;
            1:       i4.start  = st;
            2:       i8a.start = st;
            default: i8b.start = st;
        endcase
    endtask

    task automatic read_status(input int sel, output logic dn, output logic bz);
        case (sel)
            0:       begin dn = i16.done; bz = i16.busy; end
            1:       begin dn = i4.done;  bz = i4.busy;  end
            2:       begin dn = i8a.done; bz = i8a.busy; end
            default: begin dn = i8b.done; bz = i8b.busy; end
        endcase
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic co, input logic ov,
                                input int due, input string nm);
        exp_t e;
        e.sum = s; e.cout = co; e.ovf = ov; e.due = due; e.name = nm;
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse.
    task automatic mon(input int sel, input logic [15:0] s, input logic co,
                       input logic ov, input logic bz);
        exp_t e;
        if (qsize(sel) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done dut%0d got done=1 required done=0", sel);
        end else begin
            e = qpop(sel);
            chk({e.name, "_sum"}, {16'h0, s}, {16'h0, e.sum});
            chk({e.name, "_cout"}, {31'h0, co}, {31'h0, e.cout});
            chk({e.name, "_ovf"}, {31'h0, ov}, {31'h0, e.ovf});
            chk({e.name, "_latency"}, cyc, e.due);
            chk({e.name, "_busy_with_done"}, {31'h0, bz}, 32'h0);
            $display("result %s sum=%h cout=%b ovf=%b cycle=%0d", e.name, s, co, ov, cyc);
        end
    endtask

    always @(negedge clk) if (i16.done === 1'b1) mon(0, i16.sum, i16.cout, i16.ovf, i16.busy);
    always @(negedge clk) if (i4.done === 1'b1)  mon(1, {12'h0, i4.sum}, i4.cout, i4.ovf, i4.busy);
    always @(negedge clk) if (i8a.done === 1'b1) mon(2, {8'h0, i8a.sum}, i8a.cout, i8a.ovf, i8a.busy);
    always @(negedge clk) if (i8b.done === 1'b1) mon(3, {8'h0, i8b.sum}, i8b.cout, i8b.ovf, i8b.busy);

    task automatic wait_empty(input int sel, input int limit, input string nm);
        for (int k = 0; k < limit; k++) begin
            if (qsize(sel) == 0) break;
            @(negedge clk);
        end
        if (qsize(sel) != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got pending=%0d required pending=0", nm, qsize(sel));
        end
    endtask

    // One isolated operation: checks busy length and that done is a single pulse.
    task automatic op(input int sel, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub, input logic [15:0] es,
                      input logic ec, input logic eo, input string nm);
        int   n;
        int   e0;
        int   nbusy;
        logic dn;
        logic bz;
        logic seen;
        n = nval(sel);
        @(negedge clk);
        drive(sel, 1'b1, a, b, cin, sub);
        @(posedge clk);
        #1;
        e0 = cyc;
        qpush(sel, mk(es, ec, eo, e0 + n, nm));
        set_start(sel, 1'b0);
        nbusy = 0;
        seen  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            read_status(sel, dn, bz);
            if (dn) begin
                seen = 1'b1;
                break;
            end
            if (bz) nbusy++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout got done=0 required done=1", nm);
        end else begin
            chk({nm, "_busy_cycles"}, nbusy, n);
            @(negedge clk);
            read_status(sel, dn, bz);
            chk({nm, "_done_pulse"}, {31'h0, dn}, 32'h0);
        end
    endtask

    function automatic exp_t ref4(input logic [3:0] a, input logic [3:0] b,
                                  input logic cin, input logic sub);
        logic [3:0] bb;
        logic [4:0] full;
        exp_t       e;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {4'h0, cin ^ sub};
        e.sum  = {12'h0, full[3:0]};
        e.cout = full[4];
        e.ovf  = (a[3] == bb[3]) && (full[3] != a[3]);
        e.due  = 0;
        e.name = "";
        return e;
    endfunction

    initial begin
        int   e0;
        exp_t r;
        logic [8:0] v;
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_sum",  {16'h0, i16.sum}, 32'h0);
        chk("reset_cout", {31'h0, i16.cout}, 32'h0);
        chk("reset_ovf",  {31'h0, i16.ovf}, 32'h0);
        chk("reset_busy", {31'h0, i16.busy}, 32'h0);
        chk("reset_done", {31'h0, i16.done}, 32'h0);
        rst_n = 1'b1;

        op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");
        op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_carry");
        op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
        op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        op(0, 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, "sub_borrow");

        // Second start during RUN must be ignored.
        @(negedge clk);
        drive(0, 1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        e0 = cyc;
        qpush(0, mk(16'h5555, 1'b0, 1'b0, e0 + 4, "start_in_run"));
        set_start(0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        drive(0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        set_start(0, 1'b0);
        wait_empty(0, 20, "start_in_run");
        repeat (8) @(negedge clk);

        // Start held high: three results, one every N+1 cycles.
        @(negedge clk);
        drive(0, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        e0 = cyc;
        qpush(0, mk(16'h8000, 1'b0, 1'b1, e0 + 4,  "held_0"));
        qpush(0, mk(16'h8000, 1'b0, 1'b1, e0 + 9,  "held_1"));
        qpush(0, mk(16'h8000, 1'b0, 1'b1, e0 + 14, "held_2"));
        repeat (10) @(posedge clk);
        #1;
        set_start(0, 1'b0);
        wait_empty(0, 30, "held");
        repeat (4) @(negedge clk);

        // Reset in RUN cycle 2 aborts with no done.
        @(negedge clk);
        drive(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        set_start(0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_sum",  {16'h0, i16.sum}, 32'h0);
        chk("abort_cout", {31'h0, i16.cout}, 32'h0);
        chk("abort_ovf",  {31'h0, i16.ovf}, 32'h0);
        chk("abort_busy", {31'h0, i16.busy}, 32'h0);
        chk("abort_done", {31'h0, i16.done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "after_reset");

        // Exhaustive sweep on the 4-bit bit-serial instance.
        for (int sb = 0; sb < 2; sb++) begin
            for (int k = 0; k < 512; k++) begin
                v = 9'(k);
                r = ref4(v[8:5], v[4:1], v[0], sb[0]);
                op(1, {12'h0, v[8:5]}, {12'h0, v[4:1]}, v[0], sb[0], r.sum, r.cout, r.ovf,
                   $sformatf("sweep_s%0d_%0d", sb, k));
            end
        end

        // Parameter corners.
        op(2, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "w8d8_carry");
        op(3, 16'h0080, 16'h0080, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "w8d1_ovf");

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/adder_seq_n.md
# adder_seq_n

Parametrised digit-serial adder/subtractor: the sequential successor to the 4-bit ripple-carry adder. Operands are captured on a start strobe and summed DIGIT bits per clock through a single DIGIT-bit adder slice, which trades latency for area at wide operand widths. Adds add/subtract mode, signed-overflow detection and a start/busy/done handshake, so the block can be driven by a controlling FSM rather than static switches.

## Interface
- WIDTH, 16, operand/result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits processed per clock; 1 gives a bit-serial adder, DIGIT = WIDTH gives a single-cycle adder.
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on the rising edge of clk.
- a  input  WIDTH  operand A; sampled when start is accepted.
- b  input  WIDTH  operand B; sampled when start is accepted.
- cin  input  1  carry-in (add) or borrow-in (sub); sampled with operands.
- sub  input  1  mode: 0 computes a+b+cin, 1 computes a-b-cin; sampled with operands.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse when the result registers update.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  raw carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  output  1  two's-complement overflow, equal to carry into MSB XOR carry out of MSB.

## Operation
- Define N = WIDTH/DIGIT.
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0. The internal digit counter and working registers are cleared.
- Accepting a start:
  - start is accepted in IDLE or DONE; start in RUN is ignored.
  - On acceptance, latch a, and latch b XOR {WIDTH{sub}}.
  - Initialise the carry register to cin XOR sub.
  - Clear the digit counter and go to RUN.
- RUN, one digit per edge:
  - Add the low DIGIT bits of the A and B shift registers plus the carry register.
  - Shift the digit result into the working sum register from the MSB end.
  - Update the carry register and increment the counter.
- Leaving RUN:
  - Exit after the edge that processes digit N-1.
  - On that edge, copy the working sum to sum and load cout.
  - Load ovf from the carry into and out of bit DIGIT-1 of the final digit.
  - Go to DONE.
- DONE lasts exactly one cycle. It goes to IDLE, or back to RUN if start is asserted.
- Output hold:
  - sum, cout and ovf change only on the DONE-entry edge.
  - They hold their value through later IDLE and RUN cycles, until the next completion or reset.
- Asynchronous reset asserted mid-RUN aborts the operation. All outputs return to their reset values immediately, with no done pulse.
- For DIGIT = WIDTH: RUN lasts one cycle, so the latency rules below still hold with N = 1.

## Timing
- Edge E0 samples start=1 while in IDLE or DONE.
- busy is 1 after edges E0 through E(N-1), i.e. for N cycles.
- After edge EN: busy=0, done=1, and sum, cout and ovf are valid.
- done returns to 0 after edge E(N+1), unless a new operation completes then. That cannot happen, because N ≥ 1.
- Latency from the start edge to done: N+1 edges.
- Back-to-back throughput: one operation per N+1 cycles, with start held high or re-asserted during DONE.
- done and busy are never high in the same cycle.
- All outputs are registered; no combinational path runs from any input to any output.

## Test plan
- Default parameters (WIDTH=16, DIGIT=4):
  - Stimulus: a=0x1234, b=0x4321, cin=0, sub=0.
  - Required: busy high for 4 cycles; done at the 5th edge after start; sum=0x5555, cout=0, ovf=0.
- Carry and overflow, default parameters:
  - Stimulus: 0xFFFF+0x0001, cin=0. Required: sum=0x0000, cout=1, ovf=0.
  - Stimulus: 0x7FFF+0x0001, cin=0. Required: sum=0x8000, cout=0, ovf=1.
- Subtract, default parameters:
  - Stimulus: 0x0005-0x0007, cin=0. Required: sum=0xFFFE, cout=0, ovf=0.
  - Stimulus: 0x8000-0x0001, cin=0. Required: sum=0x7FFF, cout=1, ovf=1.
  - Stimulus: 0x0010-0x0001, cin=1. Required: sum=0x000E.
- Handshake, default parameters:
  - Stimulus: a second start pulse during RUN. Required: ignored; result and latency unchanged.
  - Stimulus: start held high continuously. Required: done pulses every 5 cycles.
  - Stimulus: rst_n pulsed low at RUN cycle 2. Required: outputs 0 immediately; no done; the next start works normally.
- Exhaustive sweep at WIDTH=4, DIGIT=1:
  - Stimulus: sweep {a,b,cin} from 0 to 511, for sub=0 and sub=1.
  - Required: {cout,sum} matches a+b+cin, and a+~b+!cin respectively, modulo 32. ovf matches the signed reference model. done arrives 5 edges after each start.
- Parameter corners:
  - Stimulus: WIDTH=8, DIGIT=8 with 0xFF+0x01. Required: done after 2 edges; sum=0x00, cout=1.
  - Stimulus: WIDTH=8, DIGIT=1 with 0x80+0x80. Required: done after 9 edges; sum=0x00, cout=1, ovf=1.
